// File: rtl/reg_file_sb_if.sv
// Register file / scoreboard bus.
// Groups the decode-side read/issue signals and the writeback signals.
//   master : pipeline side (drives addresses, writeback, issue)
//   slave  : register file (returns read data, pending bits, busy count)
// Handshake: regwrite and issue_valid are single-cycle qualifiers with no
// ready; each cycle either is high counts as exactly one transaction,
// accepted unconditionally at the next rising clock edge.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_READ = 2
);
  logic [N_READ*ADDR_W-1:0] read_reg;
  logic [N_READ*DATA_W-1:0] read_data;
  logic [N_READ-1:0]        read_pending;
  logic                     regwrite;
  logic [ADDR_W-1:0]        write_reg;
  logic [DATA_W-1:0]        write_data;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_reg;
  logic [ADDR_W:0]          busy_count;

  modport master (
    output read_reg, regwrite, write_reg, write_data, issue_valid, issue_reg,
    input  read_data, read_pending, busy_count
  );

  modport slave (
    input  read_reg, regwrite, write_reg, write_data, issue_valid, issue_reg,
    output read_data, read_pending, busy_count
  );
endinterface

// File: rtl/reg_file_sb.sv
// Parametrised register file with a per-register pending scoreboard.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears data, pending bits, count)
//   bus  : reg_file_sb_if.slave
//          read_reg/read_data/read_pending : N_READ combinational read ports
//          regwrite/write_reg/write_data   : writeback (clears pending bit)
//          issue_valid/issue_reg           : issue (sets pending bit)
//          busy_count                      : registered number of pending regs
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_READ   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]  busy_q, busy_d;

  logic wr_en, iss_en, cnt_inc, cnt_dec;

  // Register 0 swallows writes and issues when it is hardwired to zero.
  assign wr_en  = bus.regwrite    && !((ZERO_REG != 0) && (bus.write_reg == '0));
  assign iss_en = bus.issue_valid && !((ZERO_REG != 0) && (bus.issue_reg == '0));

  always_comb begin
    regs_d  = regs_q;
    pend_d  = pend_q;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    if (wr_en) begin
      regs_d[bus.write_reg] = bus.write_data;
      pend_d[bus.write_reg] = 1'b0;
    end
    // Issue is applied after writeback so a same-register issue wins:
    // a new producer is in flight.
    if (iss_en) begin
      pend_d[bus.issue_reg] = 1'b1;
    end
    cnt_inc = iss_en && !pend_q[bus.issue_reg];
    cnt_dec = wr_en && pend_q[bus.write_reg] &&
              !(iss_en && (bus.issue_reg == bus.write_reg));
    busy_d  = busy_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end

  assign bus.busy_count = busy_q;

  for (genvar k = 0; k < N_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic              byp;

    assign ra      = bus.read_reg[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);
    // Forward a same-cycle writeback; the zero register is never forwarded.
    assign byp     = (BYPASS != 0) && bus.regwrite && (bus.write_reg == ra) && !is_zero;

    assign bus.read_data[k*DATA_W +: DATA_W] =
      is_zero ? '0 : (byp ? bus.write_data : regs_q[ra]);
    assign bus.read_pending[k] = !is_zero && !byp && pend_q[ra];
  end
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int N_READ = 2;
  localparam int DEPTH  = 32;

  logic clk;
  logic rst;

  reg_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_READ(N_READ)) bus ();

  reg_file_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_READ(N_READ), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model (state as seen after the last edge)
  logic [DATA_W-1:0] m_regs [DEPTH];
  logic              m_pend [DEPTH];

  // scoreboard: expected value plus which output it belongs to
  logic [31:0] exp_q[$];
  int          sel_q[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int model_busy();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  function automatic string sel_name(input int s);
    case (s)
      0: return "rdata0";
      1: return "rdata1";
      2: return "rpend0";
      3: return "rpend1";
      default: return "busy";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int s);
    case (s)
      0: return bus.read_data[31:0];
      1: return bus.read_data[63:32];
      2: return {31'b0, bus.read_pending[0]};
      3: return {31'b0, bus.read_pending[1]};
      default: return {26'b0, bus.busy_count};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // One clock cycle: drive at negedge, push expectations, compare, update model.
  task automatic do_cycle(input logic [4:0] rd0, input logic [4:0] rd1,
                          input logic we, input logic [4:0] wr, input logic [31:0] wd,
                          input logic iv, input logic [4:0] ir, input logic r);
    logic [4:0] addr [2];
    @(negedge clk);
    rst             = r;
    bus.read_reg    = {rd1, rd0};
    bus.regwrite    = we;
    bus.write_reg   = wr;
    bus.write_data  = wd;
    bus.issue_valid = iv;
    bus.issue_reg   = ir;
    #1;
    addr[0] = rd0;
    addr[1] = rd1;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] ed;
      logic        ep;
      if (addr[k] == 5'd0) begin
        ed = '0; ep = 1'b0;
      end else if (we && wr == addr[k]) begin
        ed = wd; ep = 1'b0;
      end else begin
        ed = m_regs[addr[k]]; ep = m_pend[addr[k]];
      end
      exp_q.push_back(ed);         sel_q.push_back(k);
      exp_q.push_back({31'b0, ep}); sel_q.push_back(k + 2);
    end
    exp_q.push_back(32'(model_busy())); sel_q.push_back(4);
    while (exp_q.size() > 0) begin
      int          s;
      logic [31:0] e;
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      check(sel_name(s), observe(s), e);
    end
    // effect of the coming edge
    if (r) begin
      model_reset();
    end else begin
      if (we && wr != 5'd0) begin
        m_regs[wr] = wd;
        m_pend[wr] = 1'b0;
      end
      if (iv && ir != 5'd0) m_pend[ir] = 1'b1;
    end
  endtask

  task automatic idle(input logic [4:0] rd0, input logic [4:0] rd1);
    do_cycle(rd0, rd1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.read_reg = '0; bus.regwrite = 1'b0; bus.write_reg = '0;
    bus.write_data = '0; bus.issue_valid = 1'b0; bus.issue_reg = '0;
    repeat (3) @(posedge clk);
    model_reset();

    // reset state
    do_cycle(5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    check("reset_busy", {26'b0, bus.busy_count}, 32'd0);
    check("reset_rdata", bus.read_data, 64'h0);

    // bypass write to r3
    do_cycle(5'd0, 5'd3, 1'b1, 5'd3, 32'h1111, 1'b0, 5'd0, 1'b0);
    check("bypass_r3", bus.read_data[63:32], 32'h1111);
    idle(5'd0, 5'd3);
    check("stored_r3", bus.read_data[63:32], 32'h1111);

    // write to zero register is dropped
    do_cycle(5'd0, 5'd3, 1'b1, 5'd0, 32'h2222, 1'b0, 5'd0, 1'b0);
    check("r0_same", bus.read_data[31:0], 32'h0);
    idle(5'd0, 5'd3);
    check("r0_next", bus.read_data[31:0], 32'h0);

    // issue r5 then writeback r5
    do_cycle(5'd5, 5'd1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0);
    check("issue_not_yet", {31'b0, bus.read_pending[0]}, 32'd0);
    idle(5'd5, 5'd1);
    check("r5_pending", {31'b0, bus.read_pending[0]}, 32'd1);
    check("busy_1", {26'b0, bus.busy_count}, 32'd1);
    do_cycle(5'd5, 5'd1, 1'b1, 5'd5, 32'hABCD, 1'b0, 5'd0, 1'b0);
    check("r5_byp_pend", {31'b0, bus.read_pending[0]}, 32'd0);
    check("r5_byp_data", bus.read_data[31:0], 32'hABCD);
    idle(5'd5, 5'd1);
    check("busy_0", {26'b0, bus.busy_count}, 32'd0);

    // issue and writeback r7 together: issue wins
    do_cycle(5'd7, 5'd0, 1'b1, 5'd7, 32'h55, 1'b1, 5'd7, 1'b0);
    idle(5'd7, 5'd0);
    check("r7_data", bus.read_data[31:0], 32'h55);
    check("r7_pend", {31'b0, bus.read_pending[0]}, 32'd1);
    check("r7_busy", {26'b0, bus.busy_count}, 32'd1);
    do_cycle(5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    idle(5'd7, 5'd0);
    check("r7_reissue_busy", {26'b0, bus.busy_count}, 32'd1);

    // issue to r0 is dropped
    do_cycle(5'd0, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
    idle(5'd0, 5'd7);
    check("r0_issue_busy", {26'b0, bus.busy_count}, 32'd1);

    // issues then mid-sequence reset
    do_cycle(5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0);
    do_cycle(5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
    do_cycle(5'd1, 5'd2, 1'b1, 5'd9, 32'h99, 1'b1, 5'd3, 1'b0);
    do_cycle(5'd3, 5'd9, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 1'b1);
    idle(5'd3, 5'd4);
    check("rst_busy", {26'b0, bus.busy_count}, 32'd0);
    check("rst_pend", {30'b0, bus.read_pending}, 32'd0);
    for (int a = 0; a < DEPTH; a += 2) idle(5'(a), 5'(a + 1));

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      do_cycle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               ($urandom_range(0, 99) < 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
